// File: rtl/fpu_result_collector.sv
// FPU result collector: show-ahead result FIFO with per-status event
// counters, drop accounting and a sticky drop flag.
module fpu_result_collector #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clock_100Khz,
    input  logic                     reset,
    input  logic                     res_valid_in,
    input  logic [31:0]              data_in,
    input  logic [3:0]               status_in,
    input  logic                     clr_in,
    input  logic                     rd_en_in,
    output logic                     out_valid,
    output logic [31:0]              out_data,
    output logic [3:0]               out_status,
    output logic                     out_is_zero,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     full,
    output logic [CNT_W-1:0]         cnt_ovf,
    output logic [CNT_W-1:0]         cnt_unf,
    output logic [CNT_W-1:0]         cnt_exact,
    output logic [CNT_W-1:0]         cnt_inexact,
    output logic [CNT_W-1:0]         cnt_invalid,
    output logic [CNT_W-1:0]         cnt_drop,
    output logic                     err_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    // Each entry holds {result word, status code}.
    logic [35:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [FW-1:0] fill_q;
    logic [35:0]   head;

    logic pop;
    logic push;
    logic drop;
    logic is_ovf;
    logic is_unf;
    logic is_exact;
    logic is_inexact;
    logic is_invalid;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign out_valid = (fill_q != '0);
    assign full      = (fill_q == FW'(DEPTH));
    assign fill      = fill_q;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts
    // a result when the consumer reads.
    assign pop  = rd_en_in & out_valid;
    assign push = res_valid_in & (~full | pop);
    assign drop = res_valid_in & full & ~pop;

    assign is_ovf     = res_valid_in & (status_in == 4'd0);
    assign is_unf     = res_valid_in & (status_in == 4'd1);
    assign is_exact   = res_valid_in & (status_in == 4'd2);
    assign is_inexact = res_valid_in & (status_in == 4'd3);
    assign is_invalid = res_valid_in & (status_in > 4'd3);

    // Head entry is presented straight from storage; outputs read zero when empty.
    assign head        = mem[rd_ptr];
    assign out_data    = out_valid ? head[35:4] : 32'd0;
    assign out_status  = out_valid ? head[3:0]  : 4'd0;
    assign out_is_zero = out_valid & (head[34:4] == 31'd0);

    // Storage write; contents are not reset, occupancy decides validity.
    always_ff @(posedge clock_100Khz) begin
        if (push && !clr_in) begin
            mem[wr_ptr] <= {data_in, status_in};
        end
    end

    // Pointers and occupancy; clear overrides any push or pop that cycle.
    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
        end else if (clr_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      fill_q <= fill_q + FW'(1);
            else if (pop && !push) fill_q <= fill_q - FW'(1);
        end
    end

    // Event counters and sticky drop flag; every sample is classified, dropped or not.
    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            cnt_ovf     <= '0;
            cnt_unf     <= '0;
            cnt_exact   <= '0;
            cnt_inexact <= '0;
            cnt_invalid <= '0;
            cnt_drop    <= '0;
            err_drop    <= 1'b0;
        end else if (clr_in) begin
            cnt_ovf     <= '0;
            cnt_unf     <= '0;
            cnt_exact   <= '0;
            cnt_inexact <= '0;
            cnt_invalid <= '0;
            cnt_drop    <= '0;
            err_drop    <= 1'b0;
        end else begin
            if (is_ovf)     cnt_ovf     <= sat_inc(cnt_ovf);
            if (is_unf)     cnt_unf     <= sat_inc(cnt_unf);
            if (is_exact)   cnt_exact   <= sat_inc(cnt_exact);
            if (is_inexact) cnt_inexact <= sat_inc(cnt_inexact);
            if (is_invalid) cnt_invalid <= sat_inc(cnt_invalid);
            if (drop) begin
                cnt_drop <= sat_inc(cnt_drop);
                err_drop <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fpu_result_collector.md
FPU_RESULT_COLLECTOR -- requirements
Module: fpu_result_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 8, result FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, width of every event counter.
REQ-003 SHALL have port clock_100Khz  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port res_valid_in  input  1  FPU result strobe; data_in/status_in are sampled when high.
REQ-006 SHALL have port data_in  input  32  FPU result: [31] sign, [30:21] exponent (bias 511), [20:0] mantissa.
REQ-007 SHALL have port status_in  input  4  FPU status: 0 OVERFLOW, 1 UNDERFLOW, 2 EXACT, 3 INEXACT, 4..15 invalid.
REQ-008 SHALL have port clr_in  input  1  synchronous clear of FIFO, counters and sticky flag.
REQ-009 SHALL have port rd_en_in  input  1  consumer pop request.
REQ-010 SHALL have port out_valid  output  1  FIFO head is valid (FIFO not empty).
REQ-011 SHALL have port out_data  output  32  FIFO head result word.
REQ-012 SHALL have port out_status  output  4  FIFO head status code, stored unmodified.
REQ-013 SHALL have port out_is_zero  output  1  FIFO head has exponent == 0 and mantissa == 0, either sign.
REQ-014 SHALL have port fill  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-015 SHALL have port full  output  1  fill == DEPTH.
REQ-016 SHALL have ports cnt_ovf, cnt_unf, cnt_exact, cnt_inexact, cnt_invalid, cnt_drop  output  CNT_W each  event counters.
REQ-017 SHALL have port err_drop  output  1  sticky flag: at least one result dropped since reset/clear.

Function
REQ-018 SHALL implement a show-ahead FIFO: out_data/out_status/out_is_zero reflect the head entry combinationally from storage whenever out_valid=1.
REQ-019 SHALL push {data_in, status_in} on a cycle with res_valid_in=1 and full=0; the entry is visible on out_* the next cycle if the FIFO was empty (1-cycle latency).
REQ-020 SHALL pop the head on a cycle with rd_en_in=1 and out_valid=1; rd_en_in with out_valid=0 SHALL be ignored with no state change.
REQ-021 SHALL, on simultaneous push and pop, perform both, leaving fill unchanged; this SHALL hold when full=1 (the new result is accepted, no drop).
REQ-022 SHALL, when res_valid_in=1, full=1 and no pop that cycle, discard the result, increment cnt_drop and set err_drop.
REQ-023 SHALL wrap read and write pointers modulo DEPTH with no gap or duplicate entries.
REQ-024 SHALL increment exactly one of cnt_ovf/cnt_unf/cnt_exact/cnt_inexact/cnt_invalid, selected by status_in, for every res_valid_in=1 cycle, including dropped results.
REQ-025 SHALL saturate every counter at 2^CNT_W-1; a saturated counter SHALL hold.
REQ-026 SHALL, on clr_in=1, empty the FIFO and zero all counters and err_drop next cycle; clr_in SHALL take priority over a simultaneous push, pop or count, and that cycle's sample SHALL be neither stored nor counted.

Reset
REQ-027 SHALL, while reset=0, asynchronously force fill=0, out_valid=0, full=0, err_drop=0 and all counters to 0; FIFO storage contents need not be reset.
REQ-028 SHALL, with out_valid=0, drive out_data=0, out_status=0 and out_is_zero=0.
REQ-029 SHALL abandon any push/pop in progress when reset asserts mid-operation and SHALL accept a push on the first rising edge after reset deasserts.

Verification
REQ-030 SHALL pass: after reset, push 0x40000000 (2.0) with status 2 -> next cycle out_valid=1, out_data=0x40000000, out_is_zero=0, cnt_exact=1, fill=1.
REQ-031 SHALL pass: push 0x00000000 then 0x80000000 (both zero) with status 2, pop twice -> out_is_zero=1 for both heads, then out_valid=0 and fill=0.
REQ-032 SHALL pass: push DEPTH+1 results 0x3FE00000 (1.0) with no pop -> full=1, fill=8, cnt_drop=1, err_drop=1, cnt_exact=9.
REQ-033 SHALL pass: with full=1, push 0xC0400000 (-8.0) and pop in the same cycle -> fill stays 8, cnt_drop unchanged, 0xC0400000 emerges after 7 more pops.
REQ-034 SHALL pass: push status codes 0, 1, 3, 9 -> cnt_ovf=cnt_unf=cnt_inexact=cnt_invalid=1, and out_status sequence 0, 1, 3, 9 on popping.
REQ-035 SHALL pass: with fill=5 and counters nonzero, assert clr_in together with res_valid_in (0x40100000, 3.0) -> next cycle fill=0, out_valid=0, all counters 0, err_drop=0.
